// File: rtl/fetch_unit_if.sv
// Bundles the fetch stage's instruction-memory, control and IF/ID signals.
// The master modport is the fetch unit's view; the slave modport is the surrounding pipeline's view.
interface fetch_unit_if;
   logic [31:0] pc_out;
   logic [31:0] imem_instruction;
   logic        stall;
   logic        branch_taken;
   logic [31:0] branch_target;
   logic        jump;
   logic [25:0] jump_index;
   logic [31:0] if_id_instruction;
   logic [31:0] if_id_pc_plus4;
   logic        if_id_valid;
   logic        addr_error;

   modport master (
      output pc_out,
      input  imem_instruction,
      input  stall,
      input  branch_taken,
      input  branch_target,
      input  jump,
      input  jump_index,
      output if_id_instruction,
      output if_id_pc_plus4,
      output if_id_valid,
      output addr_error
   );

   modport slave (
      input  pc_out,
      output imem_instruction,
      output stall,
      output branch_taken,
      output branch_target,
      output jump,
      output jump_index,
      input  if_id_instruction,
      input  if_id_pc_plus4,
      input  if_id_valid,
      input  addr_error
   );
endinterface

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: holds the PC, handles redirects and stalls, and registers
// the fetched word into the IF/ID register. Every output comes straight from a flop.
module fetch_unit #(
   parameter logic [31:0] RESET_PC   = 32'h0000_0000,
   parameter int          IMEM_BYTES = 256
) (
   input  logic         clk,
   input  logic         reset,
   fetch_unit_if.master bus
);

   localparam logic [31:0] IMEM_LIMIT = 32'(IMEM_BYTES);

   logic [31:0] r_pc;
   logic [31:0] r_if_id_instruction;
   logic [31:0] r_if_id_pc_plus4;
   logic        r_if_id_valid;
   logic        r_addr_error;

   logic [31:0] w_pc_plus4;
   logic [31:0] w_jump_target;
   logic [31:0] w_raw_target;
   logic        w_redirect;
   logic        w_in_range;

   // NOTE: every variable assigned in always_comb gets a value on every path, so no latch is inferred.
   always_comb begin
      w_pc_plus4    = r_pc + 32'd4;
      w_jump_target = {w_pc_plus4[31:28], bus.jump_index, 2'b00};
      w_redirect    = bus.branch_taken | bus.jump;
      w_raw_target  = bus.branch_taken ? bus.branch_target : w_jump_target;
      w_in_range    = (r_pc < IMEM_LIMIT);
   end

   // Redirect outranks stall; stall outranks normal fetch. addr_error is sticky until reset.
   // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_pc                <= RESET_PC;
         r_if_id_instruction <= 32'h0;
         r_if_id_pc_plus4    <= 32'h0;
         r_if_id_valid       <= 1'b0;
         r_addr_error        <= 1'b0;
      end else if (w_redirect) begin
         r_pc                <= {w_raw_target[31:2], 2'b00};
         r_if_id_instruction <= 32'h0;
         r_if_id_pc_plus4    <= 32'h0;
         r_if_id_valid       <= 1'b0;
         if (w_raw_target[1:0] != 2'b00) r_addr_error <= 1'b1;
      end else if (!bus.stall) begin
         r_pc <= w_pc_plus4;
         if (w_in_range) begin
            r_if_id_instruction <= bus.imem_instruction;
            r_if_id_pc_plus4    <= w_pc_plus4;
            r_if_id_valid       <= 1'b1;
         end else begin
            r_if_id_instruction <= 32'h0;
            r_if_id_pc_plus4    <= 32'h0;
            r_if_id_valid       <= 1'b0;
            r_addr_error        <= 1'b1;
         end
      end
   end

   assign bus.pc_out            = r_pc;
   assign bus.if_id_instruction = r_if_id_instruction;
   assign bus.if_id_pc_plus4    = r_if_id_pc_plus4;
   assign bus.if_id_valid       = r_if_id_valid;
   assign bus.addr_error        = r_addr_error;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: sequential fetch, redirects, stalls, address errors
// and asynchronous reset, against hand-computed expected values.
module tb_fetch_unit;

   logic clk;
   logic reset;
   int   n_checks;
   int   n_fail;

   logic [31:0] mem [0:63];

   fetch_unit_if bus ();

   fetch_unit #(
      .RESET_PC  (32'h0000_0000),
      .IMEM_BYTES(256)
   ) u_dut (
      .clk  (clk),
      .reset(reset),
      .bus  (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Combinational instruction memory; out-of-range reads return a marker word.
   always_comb begin
      if (bus.pc_out < 32'd256) bus.imem_instruction = mem[bus.pc_out[7:2]];
      else                      bus.imem_instruction = 32'hDEAD_BEEF;
   end

   task automatic check(input string tag, input logic [31:0] actual, input logic [31:0] expected);
      n_checks++;
      if (actual !== expected) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, actual, expected);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic check_if_id(input string tag, input logic [31:0] instr,
                              input logic [31:0] pc4, input logic valid);
      check({tag, "_instr"}, bus.if_id_instruction, instr);
      check({tag, "_pc4"},   bus.if_id_pc_plus4,    pc4);
      check({tag, "_valid"}, {31'h0, bus.if_id_valid}, {31'h0, valid});
   endtask

   task automatic clear_ctrl();
      bus.stall         = 1'b0;
      bus.branch_taken  = 1'b0;
      bus.branch_target = 32'h0;
      bus.jump          = 1'b0;
      bus.jump_index    = 26'h0;
   endtask

   initial begin
      n_checks = 0;
      n_fail   = 0;
      for (int k = 0; k < 64; k++) mem[k] = 32'hA000_0000 | k;
      mem[0] = 32'h2011_0001;
      mem[1] = 32'h2012_0002;
      mem[2] = 32'h1251_0005;

      reset = 1'b1;
      clear_ctrl();
      @(negedge clk);
      check("rst_pc", bus.pc_out, 32'h0);
      check_if_id("rst", 32'h0, 32'h0, 1'b0);
      check("rst_err", {31'h0, bus.addr_error}, 32'h0);

      // Sequential fetch from reset.
      reset = 1'b0;
      tick();
      check_if_id("seq0", 32'h2011_0001, 32'd4, 1'b1);
      check("seq0_pc", bus.pc_out, 32'd4);
      tick();
      check_if_id("seq1", 32'h2012_0002, 32'd8, 1'b1);
      check("seq1_pc", bus.pc_out, 32'd8);
      tick();
      check_if_id("seq2", 32'h1251_0005, 32'd12, 1'b1);
      check("seq2_pc", bus.pc_out, 32'd12);

      // Branch with simultaneous stall: redirect wins, one bubble.
      bus.branch_taken  = 1'b1;
      bus.branch_target = 32'h0000_0004;
      bus.stall         = 1'b1;
      tick();
      clear_ctrl();
      check("br_pc", bus.pc_out, 32'd4);
      check_if_id("br_bubble", 32'h0, 32'h0, 1'b0);
      tick();
      check_if_id("br_tgt", 32'h2012_0002, 32'd8, 1'b1);
      check("br_tgt_pc", bus.pc_out, 32'd8);

      // Stall for three edges, then resume.
      bus.stall = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         check_if_id("stall_hold", 32'h2012_0002, 32'd8, 1'b1);
         check("stall_pc", bus.pc_out, 32'd8);
      end
      bus.stall = 1'b0;
      tick();
      check_if_id("stall_resume", 32'h1251_0005, 32'd12, 1'b1);
      check("stall_resume_pc", bus.pc_out, 32'd12);

      // Advance to pc = 0x10.
      tick();
      check_if_id("seq3", 32'hA000_0003, 32'd16, 1'b1);
      check("seq3_pc", bus.pc_out, 32'h10);

      // Jump and branch together: branch wins.
      bus.jump          = 1'b1;
      bus.jump_index    = 26'h000_0002;
      bus.branch_taken  = 1'b1;
      bus.branch_target = 32'h0000_0014;
      tick();
      clear_ctrl();
      check("jb_pc", bus.pc_out, 32'h14);
      check_if_id("jb_bubble", 32'h0, 32'h0, 1'b0);

      // Jump alone: target = {pc_plus4[31:28], index, 00} = 8.
      bus.jump       = 1'b1;
      bus.jump_index = 26'h000_0002;
      tick();
      clear_ctrl();
      check("jmp_pc", bus.pc_out, 32'h8);
      check("jmp_err", {31'h0, bus.addr_error}, 32'h0);

      // Misaligned branch target: PC aligned down, sticky error.
      bus.branch_taken  = 1'b1;
      bus.branch_target = 32'h0000_0006;
      tick();
      clear_ctrl();
      check("mis_pc", bus.pc_out, 32'd4);
      check("mis_err", {31'h0, bus.addr_error}, 32'h1);
      tick();
      check("mis_err_sticky", {31'h0, bus.addr_error}, 32'h1);
      check_if_id("mis_next", 32'h2012_0002, 32'd8, 1'b1);

      // Out-of-range fetch, starting from a clean error flag.
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      check("oor_rst_err", {31'h0, bus.addr_error}, 32'h0);
      bus.branch_taken  = 1'b1;
      bus.branch_target = 32'h0000_00F8;
      tick();
      clear_ctrl();
      check("oor_pc248", bus.pc_out, 32'd248);
      tick();
      tick();
      check_if_id("oor_last", 32'hA000_003F, 32'd256, 1'b1);
      check("oor_pc256", bus.pc_out, 32'd256);
      check("oor_err_pre", {31'h0, bus.addr_error}, 32'h0);
      tick();
      check_if_id("oor_bubble", 32'h0, 32'h0, 1'b0);
      check("oor_pc260", bus.pc_out, 32'd260);
      check("oor_err", {31'h0, bus.addr_error}, 32'h1);

      // PC wrap: 0xFFFFFFFC + 4 = 0.
      bus.branch_taken  = 1'b1;
      bus.branch_target = 32'hFFFF_FFFC;
      tick();
      clear_ctrl();
      check("wrap_pc_hi", bus.pc_out, 32'hFFFF_FFFC);
      tick();
      check("wrap_pc", bus.pc_out, 32'h0);

      // Load a valid instruction, then reset asynchronously with a redirect pending.
      tick();
      check_if_id("pre_arst", 32'h2011_0001, 32'd4, 1'b1);
      bus.branch_taken  = 1'b1;
      bus.branch_target = 32'h0000_0040;
      #2;
      reset = 1'b1;
      #1;
      check("arst_pc", bus.pc_out, 32'h0);
      check_if_id("arst", 32'h0, 32'h0, 1'b0);
      check("arst_err", {31'h0, bus.addr_error}, 32'h0);
      tick();
      check("arst_hold_pc", bus.pc_out, 32'h0);
      reset = 1'b0;
      clear_ctrl();
      tick();
      check_if_id("post_arst", 32'h2011_0001, 32'd4, 1'b1);
      check("post_arst_pc", bus.pc_out, 32'd4);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
